board_stim_gen: RTL

//  Synthesizable N-channel stimulus generator for board self-test of cpu_top.
//  It drives the button-style inputs that a bench would otherwise drive: a delayed

---
 rtl/board_stim_gen.sv | 139 +++++++++++++
 1 files changed

// File: rtl/board_stim_gen.sv
// N-channel button-style stimulus generator: per-channel LEVEL/TOGGLE/PULSE
// sequences with start delay, period and event count, launched together by START.

module board_stim_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             stim,
  output logic             busy
);
  localparam logic [1:0] M_OFF    = 2'd0;
  localparam logic [1:0] M_LEVEL  = 2'd1;
  localparam logic [1:0] M_TOGGLE = 2'd2;
  localparam logic [1:0] M_PULSE  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_FIN} state_e;

  typedef struct packed {
    logic [1:0]       mode;
    logic [CNT_W-1:0] delay;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] count;
  } cfg_t;

  cfg_t             cfg;
  state_e           state;
  logic [CNT_W-1:0] dly_cnt, per_cnt, evt_cnt;
  logic [CNT_W-1:0] reload;
  logic             evt, last_evt;

  // PERIOD=0 behaves as 1, so both reload the period counter with 0.
  assign reload   = (cfg.period == '0) ? '0 : cfg.period - 1'b1;
  assign evt      = ((state == S_WAIT) && (dly_cnt == '0)) ||
                    ((state == S_ACTIVE) && (per_cnt == '0));
  assign last_evt = (cfg.count != '0) && (evt_cnt == cfg.count - 1'b1);
  assign busy     = (state == S_WAIT) || (state == S_ACTIVE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      stim    <= 1'b0;
      dly_cnt <= '0;
      per_cnt <= '0;
      evt_cnt <= '0;
      cfg     <= '{mode: M_OFF, delay: '0, period: CNT_W'(1), count: '0};
    end else begin
      if (cfg_we)
        cfg <= '{mode: cfg_mode, delay: cfg_delay, period: cfg_period, count: cfg_count};
      if (stop) begin
        state <= S_IDLE;
        stim  <= 1'b0;
      end else if (start) begin
        stim    <= 1'b0;
        dly_cnt <= cfg.delay;
        evt_cnt <= '0;
        state   <= (cfg.mode == M_OFF) ? S_FIN : S_WAIT;
      end else if (evt) begin
        per_cnt <= reload;
        evt_cnt <= evt_cnt + 1'b1;
        if (cfg.mode == M_LEVEL) begin
          stim  <= 1'b1;
          state <= S_FIN;
        end else begin
          stim  <= (cfg.mode == M_TOGGLE) ? ~stim : 1'b1;
          state <= last_evt ? S_FIN : S_ACTIVE;
        end
      end else begin
        if (state == S_WAIT)   dly_cnt <= dly_cnt - 1'b1;
        if (state == S_ACTIVE) per_cnt <= per_cnt - 1'b1;
        // A pulse lasts one cycle, including the final one before FIN.
        if (cfg.mode == M_PULSE && (state == S_ACTIVE || state == S_FIN))
          stim <= 1'b0;
      end
    end
  end
endmodule

module board_stim_gen #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int CH_W  = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STOP,
  input  logic             CFG_WE,
  input  logic [CH_W-1:0]  CFG_CH,
  input  logic [1:0]       CFG_MODE,
  input  logic [CNT_W-1:0] CFG_DELAY,
  input  logic [CNT_W-1:0] CFG_PERIOD,
  input  logic [CNT_W-1:0] CFG_COUNT,
  output logic [N_CH-1:0]  STIM_OUT,
  output logic             BUSY,
  output logic             DONE
);
  logic [N_CH-1:0] ch_we, ch_busy;
  logic            start_go, busy_d;

  assign BUSY     = |ch_busy;
  assign start_go = START && !STOP && !BUSY;

  for (genvar i = 0; i < N_CH; i++) begin : g_we
    assign ch_we[i] = CFG_WE && !BUSY && (CFG_CH == CH_W'(i));
  end

  board_stim_ch #(.CNT_W(CNT_W)) u_ch [N_CH-1:0] (
    .clk        (CLK),
    .rst_n      (RST_N),
    .start      (start_go),
    .stop       (STOP),
    .cfg_we     (ch_we),
    .cfg_mode   (CFG_MODE),
    .cfg_delay  (CFG_DELAY),
    .cfg_period (CFG_PERIOD),
    .cfg_count  (CFG_COUNT),
    .stim       (STIM_OUT),
    .busy       (ch_busy)
  );

  // STOP clears the busy history so an abort never looks like a completion.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      busy_d <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      busy_d <= STOP ? 1'b0 : BUSY;
      DONE   <= busy_d && !BUSY;
    end
  end
endmodule
